// File: rtl/pc_control.sv
// Program-counter sequencer: fetches an instruction, executes it for one cycle
// (or more while stalled), computes the next pc and the R7 link write.
module pc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_en,
    input  logic        jump_disp_en,
    input  logic        jr_en,
    input  logic        reg_7_en,
    input  logic        halt,
    input  logic        stall,
    input  logic [7:0]  imm8,
    input  logic [10:0] disp11,
    input  logic [15:0] rs_data,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        link_we,
    output logic [15:0] link_data,
    output logic        halted,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_next;
    logic [15:0] imm8_sext;
    logic [15:0] disp11_sext;
    logic [15:0] branch_target;
    logic [15:0] disp_target;
    logic [15:0] jr_target;
    logic [15:0] target_pc;
    logic        exec_commit;

    // Handshake: imem_req stays high in REQ until imem_ready is seen on a
    // rising edge; the word at pc is then executed in the following cycle.
    // imem_ready is a don't-care whenever imem_req is low.

    assign imm8_sext     = {{8{imm8[7]}}, imm8};
    assign disp11_sext   = {{5{disp11[10]}}, disp11};
    assign pc_plus2      = pc + 16'd2;
    assign branch_target = pc_plus2 + imm8_sext;
    assign disp_target   = pc_plus2 + disp11_sext;
    assign jr_target     = rs_data + imm8_sext;

    always_comb begin
        target_pc = pc_plus2;
        if (jr_en) begin
            target_pc = jr_target;
        end else if (jump_disp_en) begin
            target_pc = disp_target;
        end else if (branch_en) begin
            target_pc = branch_target;
        end
    end

    assign exec_commit = (state == S_EXEC) && !stall;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (imem_ready) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // Halt wins over any jump: pc freezes on the halting instruction.
                if (!stall) begin
                    if (halt) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_REQ;
                        pc_next    = target_pc;
                    end
                end
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    assign imem_req    = (state == S_REQ);
    assign instr_valid = (state == S_EXEC);
    assign halted      = (state == S_HALT);
    // Link value comes from the pre-update pc, so JALR with Rs == R7 is safe.
    assign link_we     = exec_commit && reg_7_en && !halt;
    assign link_data   = pc_plus2;
    assign state_dbg   = state;

endmodule

// File: tb/tb_pc_control.sv
// Directed and randomized checks of pc_control against a small arithmetic
// model of fetch/execute sequencing and next-pc selection.
module tb_pc_control;

    logic        clk;
    logic        rst;
    logic        branch_en;
    logic        jump_disp_en;
    logic        jr_en;
    logic        reg_7_en;
    logic        halt;
    logic        stall;
    logic [7:0]  imm8;
    logic [10:0] disp11;
    logic [15:0] rs_data;
    logic        imem_ready;
    logic        imem_req;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        link_we;
    logic [15:0] link_data;
    logic        halted;
    logic [1:0]  state_dbg;

    int          assert_cnt;
    int          fail_cnt;
    logic [15:0] m_pc;

    pc_control dut (
        .clk          (clk),
        .rst          (rst),
        .branch_en    (branch_en),
        .jump_disp_en (jump_disp_en),
        .jr_en        (jr_en),
        .reg_7_en     (reg_7_en),
        .halt         (halt),
        .stall        (stall),
        .imm8         (imm8),
        .disp11       (disp11),
        .rs_data      (rs_data),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .instr_valid  (instr_valid),
        .link_we      (link_we),
        .link_data    (link_data),
        .halted       (halted),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        branch_en    = 1'b0;
        jump_disp_en = 1'b0;
        jr_en        = 1'b0;
        reg_7_en     = 1'b0;
        halt         = 1'b0;
        stall        = 1'b0;
        imm8         = 8'h00;
        disp11       = 11'h000;
        rs_data      = 16'h0000;
    endtask

    // Random control values; the DUT must ignore them outside EXEC.
    task automatic junk_ctrl();
        branch_en    = 1'($urandom_range(0, 1));
        jump_disp_en = 1'($urandom_range(0, 1));
        jr_en        = 1'($urandom_range(0, 1));
        reg_7_en     = 1'($urandom_range(0, 1));
        halt         = 1'($urandom_range(0, 1));
        stall        = 1'($urandom_range(0, 1));
        imm8         = 8'($urandom);
        disp11       = 11'($urandom);
        rs_data      = 16'($urandom);
    endtask

    function automatic logic [15:0] model_next(input bit br, input bit jd, input bit jr,
                                               input logic [15:0] p, input logic [7:0] imm,
                                               input logic [10:0] disp, input logic [15:0] rs);
        int i_s;
        int d_s;
        int r;
        i_s = (int'(imm) >= 128) ? int'(imm) - 256 : int'(imm);
        d_s = (int'(disp) >= 1024) ? int'(disp) - 2048 : int'(disp);
        if (jr)      r = int'(rs) + i_s;
        else if (jd) r = int'(p) + 2 + d_s;
        else if (br) r = int'(p) + 2 + i_s;
        else         r = int'(p) + 2;
        return 16'(r & 32'h0000FFFF);
    endfunction

    // One instruction starting with the DUT in REQ: wt memory wait cycles,
    // stl stalled EXEC cycles, then the committing EXEC cycle.
    task automatic run_instr(input bit br, input bit jd, input bit jr, input bit l7,
                             input bit hl, input int stl, input logic [7:0] imm,
                             input logic [10:0] disp, input logic [15:0] rs, input int wt);
        logic [15:0] exp_next;
        logic [15:0] exp_p2;
        check("req_imem_req", 16'(imem_req), 16'd1);
        check("req_instr_valid", 16'(instr_valid), 16'd0);
        check("req_pc", pc, m_pc);
        repeat (wt) begin
            imem_ready = 1'b0;
            junk_ctrl();
            #1;
            check("wait_link_we", 16'(link_we), 16'd0);
            tick();
            check("wait_imem_req", 16'(imem_req), 16'd1);
            check("wait_pc", pc, m_pc);
        end
        imem_ready = 1'b1;
        junk_ctrl();
        tick();
        imem_ready = 1'($urandom_range(0, 1));
        exp_p2 = 16'((int'(m_pc) + 2) & 32'h0000FFFF);
        check("exec_instr_valid", 16'(instr_valid), 16'd1);
        check("exec_imem_req", 16'(imem_req), 16'd0);
        check("exec_pc_plus2", pc_plus2, exp_p2);
        branch_en    = br;
        jump_disp_en = jd;
        jr_en        = jr;
        reg_7_en     = l7;
        halt         = hl;
        imm8         = imm;
        disp11       = disp;
        rs_data      = rs;
        stall        = 1'b1;
        repeat (stl) begin
            #1;
            check("stall_link_we", 16'(link_we), 16'd0);
            tick();
            check("stall_instr_valid", 16'(instr_valid), 16'd1);
            check("stall_pc", pc, m_pc);
        end
        stall = 1'b0;
        #1;
        check("commit_link_we", 16'(link_we), 16'(l7 && !hl));
        check("commit_link_data", link_data, exp_p2);
        exp_next = model_next(br, jd, jr, m_pc, imm, disp, rs);
        tick();
        clear_ctrl();
        if (hl) begin
            check("halt_halted", 16'(halted), 16'd1);
            check("halt_imem_req", 16'(imem_req), 16'd0);
            check("halt_pc", pc, m_pc);
        end else begin
            m_pc = exp_next;
            check("next_pc", pc, m_pc);
            check("next_link_we", 16'(link_we), 16'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_ctrl();
        imem_ready = 1'b0;
        tick();
        m_pc = 16'h0000;
        check("rst_pc", pc, 16'h0000);
        check("rst_imem_req", 16'(imem_req), 16'd0);
        check("rst_instr_valid", 16'(instr_valid), 16'd0);
        check("rst_link_we", 16'(link_we), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        rst = 1'b0;
        #1;
        check("idle_imem_req", 16'(imem_req), 16'd0);
        tick();
        check("first_imem_req", 16'(imem_req), 16'd1);
    endtask

    initial begin
        assert_cnt = 0;
        fail_cnt   = 0;
        m_pc       = 16'h0000;
        clear_ctrl();
        imem_ready = 1'b0;
        rst        = 1'b1;
        #2;
        check("async_rst_pc", pc, 16'h0000);
        check("async_rst_halted", 16'(halted), 16'd0);
        do_reset();

        // Sequential fetch 0x0000, 0x0002, 0x0004.
        run_instr(0, 0, 0, 0, 0, 0, 8'h00, 11'h000, 16'h0000, 0);
        run_instr(0, 0, 0, 0, 0, 0, 8'h00, 11'h000, 16'h0000, 0);
        run_instr(0, 0, 0, 0, 0, 0, 8'h00, 11'h000, 16'h0000, 0);
        check("seq_pc_6", pc, 16'h0006);

        // Branch and displacement targets from 0x0010.
        run_instr(0, 0, 1, 0, 0, 0, 8'h00, 11'h000, 16'h0010, 1);
        run_instr(1, 0, 0, 0, 0, 0, 8'hFE, 11'h000, 16'h0000, 0);
        check("branch_back", pc, 16'h0010);
        run_instr(0, 1, 0, 0, 0, 0, 8'h00, 11'h010, 16'h0000, 2);
        check("disp_target", pc, 16'h0022);

        // JALR from 0x0100.
        run_instr(0, 0, 1, 0, 0, 0, 8'h00, 11'h000, 16'h0100, 0);
        run_instr(0, 0, 1, 1, 0, 0, 8'h04, 11'h000, 16'h2000, 1);
        check("jalr_target", pc, 16'h2004);

        // Stall three cycles with a link request pending.
        run_instr(0, 0, 0, 1, 0, 3, 8'h00, 11'h000, 16'h0000, 0);
        check("stall_seq", pc, 16'h2006);

        // JR beats branch.
        run_instr(1, 0, 1, 0, 0, 0, 8'h80, 11'h000, 16'h1234, 0);
        check("jr_priority", pc, 16'h11B4);

        // Odd addresses pass through untouched.
        run_instr(0, 0, 1, 0, 0, 0, 8'h01, 11'h000, 16'h0002, 0);
        check("odd_pc", pc, 16'h0003);

        for (int i = 0; i < 25; i++) begin
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                      $urandom_range(0, 2), 8'($urandom), 11'($urandom),
                      16'($urandom), $urandom_range(0, 2));
        end

        // Wrap from 0xFFFE.
        run_instr(0, 0, 1, 0, 0, 0, 8'h00, 11'h000, 16'hFFFE, 0);
        check("wrap_pc_plus2", pc_plus2, 16'h0000);
        run_instr(0, 0, 0, 0, 0, 0, 8'h00, 11'h000, 16'h0000, 0);
        check("wrap_pc", pc, 16'h0000);

        // Halt beats a jump and link, then stays halted.
        run_instr(0, 0, 1, 0, 0, 0, 8'h00, 11'h000, 16'h0040, 0);
        run_instr(0, 1, 0, 1, 1, 1, 8'h00, 11'h010, 16'h0000, 0);
        $display("halt state code %0d", state_dbg);
        repeat (4) begin
            imem_ready = 1'b1;
            junk_ctrl();
            #1;
            check("halt_hold_link_we", 16'(link_we), 16'd0);
            tick();
            check("halt_hold_halted", 16'(halted), 16'd1);
            check("halt_hold_imem_req", 16'(imem_req), 16'd0);
            check("halt_hold_instr_valid", 16'(instr_valid), 16'd0);
            check("halt_hold_pc", pc, 16'h0040);
        end

        // Reset out of HALT takes effect without a clock edge.
        clear_ctrl();
        rst = 1'b1;
        #1;
        check("halt_rst_halted", 16'(halted), 16'd0);
        check("halt_rst_pc", pc, 16'h0000);
        do_reset();

        // Reset in the middle of a memory wait.
        run_instr(0, 0, 1, 0, 0, 0, 8'h00, 11'h000, 16'h0080, 0);
        imem_ready = 1'b0;
        tick();
        check("midreq_imem_req", 16'(imem_req), 16'd1);
        rst = 1'b1;
        #1;
        check("midreq_rst_pc", pc, 16'h0000);
        check("midreq_rst_imem_req", 16'(imem_req), 16'd0);
        do_reset();
        run_instr(0, 0, 0, 0, 0, 0, 8'h00, 11'h000, 16'h0000, 1);
        check("post_rst_pc", pc, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
